// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
package dmem_pkg;

  localparam logic [1:0] DSIZE_BYTE = 2'b00;
  localparam logic [1:0] DSIZE_HALF = 2'b01;
  localparam logic [1:0] DSIZE_WORD = 2'b10;

  // Width of the wait-latency counter; latency range is 0..15.
  localparam int LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_if.sv
// Data-port bus between the MEM stage (master) and the memory responder (slave).
interface dmem_if;
  import dmem_pkg::*;

  logic [31:0] daddr;
  logic        dreq;
  logic        dwrite;
  logic [1:0]  dsize;
  logic [31:0] input_ddata;
  logic [31:0] output_ddata;
  logic        dbusy;
  logic        dready_n;
  logic        dmisalign;

  modport master (
    output daddr, dreq, dwrite, dsize, input_ddata,
    input  output_ddata, dbusy, dready_n, dmisalign
  );

  modport slave (
    input  daddr, dreq, dwrite, dsize, input_ddata,
    output output_ddata, dbusy, dready_n, dmisalign
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and write-data placement for
// stores, right-aligned zero-extended extraction for loads, misalign detect.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [4:0]  shamt;
  logic [31:0] rshift;

  assign shamt  = {addr_i, 3'b000};
  assign rshift = rword_i >> shamt;

  // Decode the access size into lane enables and aligned data.
  always_comb begin
    // NOTE: every output is given a default before the case so no latch is inferred.
    be_o       = 4'b0000;
    wword_o    = wdata_i << shamt;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    unique case (size_i)
      DSIZE_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        rdata_o = {24'h0, rshift[7:0]};
      end
      DSIZE_HALF: begin
        misalign_o = addr_i[0];
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        rdata_o    = {16'h0, rshift[15:0]};
      end
      default: begin
        // Word, and the reserved encoding treated as word.
        misalign_o = (addr_i != 2'b00);
        be_o       = 4'b1111;
        rdata_o    = rshift;
      end
    endcase
    if (misalign_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'h0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the MEM-stage data port: accepts one request, waits
// LATENCY cycles, then completes it with a one-cycle active-low ready strobe.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic [31:0]       rdata;
  logic              misalign;
  logic              in_resp;

  // Address bits above the array index wrap and are intentionally ignored.
  logic unused_daddr;
  assign unused_daddr = ^bus.daddr[31:AW+2];

  assign rword   = mem_q[addr_q[AW+1:2]];
  assign in_resp = (state_q == RESP);

  dmem_lane_align u_align (
    .addr_i    (addr_q[1:0]),
    .size_i    (size_q),
    .wdata_i   (wdata_q),
    .rword_i   (rword),
    .be_o      (be),
    .wword_o   (wword),
    .rdata_o   (rdata),
    .misalign_o(misalign)
  );

  // State, counter and request latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= DSIZE_WORD;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.dreq) begin
          addr_d  = bus.daddr[AW+1:0];
          wr_d    = bus.dwrite;
          size_d  = bus.dsize;
          wdata_d = bus.input_ddata;
          cnt_d   = LAT_W'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store commit on the edge leaving RESP; a reset already forced IDLE, dropping it.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents survive rst so it maps onto RAM.
    if (in_resp && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr_q[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  // Response outputs, forced to their idle values while reset is asserted.
  always_comb begin
    bus.dready_n     = ~in_resp;
    bus.dmisalign    = in_resp & misalign;
    bus.output_ddata = (in_resp && !wr_q) ? rdata : 32'h0;
    bus.dbusy        = rst & (((state_q == IDLE) & bus.dreq) | (state_q == WAIT));
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: one responder at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int LAT2 = 2;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dmem_if if2 ();
  dmem_if if0 ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Full access on the LATENCY=2 responder with per-cycle handshake checks.
  // Request inputs are scrambled after acceptance to show they are latched.
  task automatic access2(input string tag, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis);
    @(negedge clk);
    if2.dreq = 1'b1; if2.dwrite = wr; if2.dsize = sz;
    if2.daddr = a;   if2.input_ddata = wd;
    #1 check({tag, ".busy_req"}, 32'(if2.dbusy), 32'd1);
    for (int k = 1; k <= LAT2; k++) begin
      @(posedge clk); #1;
      check({tag, ".rdy_wait"}, 32'(if2.dready_n), 32'd1);
      check({tag, ".busy_wait"}, 32'(if2.dbusy), 32'd1);
      if2.daddr = ~a; if2.input_ddata = ~wd; if2.dsize = ~sz;
    end
    @(posedge clk); #1;
    check({tag, ".rdy_resp"}, 32'(if2.dready_n), 32'd0);
    check({tag, ".busy_resp"}, 32'(if2.dbusy), 32'd0);
    check({tag, ".data"}, if2.output_ddata, exp_rd);
    check({tag, ".mis"}, 32'(if2.dmisalign), 32'(exp_mis));
    @(negedge clk);
    if2.dreq = 1'b0;
    @(posedge clk); #1;
    check({tag, ".rdy_done"}, 32'(if2.dready_n), 32'd1);
    check({tag, ".data_done"}, if2.output_ddata, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    if2.dreq = 1'b0; if2.dwrite = 1'b0; if2.dsize = DSIZE_WORD;
    if2.daddr = '0;  if2.input_ddata = '0;
    if0.dreq = 1'b0; if0.dwrite = 1'b0; if0.dsize = DSIZE_WORD;
    if0.daddr = '0;  if0.input_ddata = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdy", 32'(if2.dready_n), 32'd1);
    check("rst.busy", 32'(if2.dbusy), 32'd0);
    check("rst.data", if2.output_ddata, 32'h0);
    check("rst.mis", 32'(if2.dmisalign), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-WAIT drops the pending store.
    access2("pre10", 1'b1, DSIZE_WORD, 32'h10, 32'h0123_4567, 32'h0, 1'b0);
    @(negedge clk);
    if2.dreq = 1'b1; if2.dwrite = 1'b1; if2.dsize = DSIZE_WORD;
    if2.daddr = 32'h10; if2.input_ddata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("midrst.busy_wait", 32'(if2.dbusy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst.busy", 32'(if2.dbusy), 32'd0);
    check("midrst.rdy", 32'(if2.dready_n), 32'd1);
    check("midrst.data", if2.output_ddata, 32'h0);
    if2.dreq = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    access2("ld10", 1'b0, DSIZE_WORD, 32'h10, 32'h0, 32'h0123_4567, 1'b0);

    // Word store then load.
    access2("st40", 1'b1, DSIZE_WORD, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0);
    access2("ld40", 1'b0, DSIZE_WORD, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte and half lanes.
    access2("stb41", 1'b1, DSIZE_BYTE, 32'h41, 32'hFFFF_FFAA, 32'h0, 1'b0);
    access2("sth42", 1'b1, DSIZE_HALF, 32'h42, 32'hFFFF_1234, 32'h0, 1'b0);
    access2("ldw40", 1'b0, DSIZE_WORD, 32'h40, 32'h0, 32'h1234_AAEF, 1'b0);
    access2("ldb43", 1'b0, DSIZE_BYTE, 32'h43, 32'h0, 32'h0000_0012, 1'b0);
    access2("ldh42", 1'b0, DSIZE_HALF, 32'h42, 32'h0, 32'h0000_1234, 1'b0);
    access2("ldb40", 1'b0, DSIZE_BYTE, 32'h40, 32'h0, 32'h0000_00EF, 1'b0);

    // Misalignment: store suppressed, load data zero.
    access2("st44", 1'b1, DSIZE_WORD, 32'h44, 32'h5566_7788, 32'h0, 1'b0);
    access2("sth45", 1'b1, DSIZE_HALF, 32'h45, 32'h0000_ABCD, 32'h0, 1'b1);
    access2("ld44", 1'b0, DSIZE_WORD, 32'h44, 32'h0, 32'h5566_7788, 1'b0);
    access2("ldw46", 1'b0, DSIZE_WORD, 32'h46, 32'h0, 32'h0, 1'b1);

    // Address wrap at 1024 words.
    access2("st1000", 1'b1, DSIZE_WORD, 32'h1000, 32'h0000_0011, 32'h0, 1'b0);
    access2("ld0", 1'b0, DSIZE_WORD, 32'h0, 32'h0, 32'h0000_0011, 1'b0);

    // LATENCY=0, dreq held across a store and a load to the same word.
    @(negedge clk);
    if0.dreq = 1'b1; if0.dwrite = 1'b1; if0.dsize = DSIZE_WORD;
    if0.daddr = 32'h80; if0.input_ddata = 32'hCAFE_F00D;
    #1 check("l0.busy_req", 32'(if0.dbusy), 32'd1);
    @(posedge clk); #1;
    check("l0.st_rdy", 32'(if0.dready_n), 32'd0);
    check("l0.st_busy", 32'(if0.dbusy), 32'd0);
    @(negedge clk);
    if0.dwrite = 1'b0; if0.input_ddata = 32'h0;
    @(posedge clk); #1;
    check("l0.gap_rdy", 32'(if0.dready_n), 32'd1);
    check("l0.gap_busy", 32'(if0.dbusy), 32'd1);
    @(posedge clk); #1;
    check("l0.ld_rdy", 32'(if0.dready_n), 32'd0);
    check("l0.ld_busy", 32'(if0.dbusy), 32'd0);
    check("l0.ld_data", if0.output_ddata, 32'hCAFE_F00D);
    @(negedge clk);
    if0.dreq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("l0.no_reaccept", 32'(if0.dready_n), 32'd1);
      check("l0.idle_busy", 32'(if0.dbusy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage pipeline's MEM stage. It samples the initiator's daddr/dreq/dwrite/dsize/write-data bus, performs the byte/half/word access against an internal memory array after a programmable wait latency, and returns read data with a one-cycle active-low ready strobe. It is the memory-side end of the stage's data port, used in simulation and FPGA builds in place of a real cache.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- LATENCY, 2: wait cycles between acceptance and response; 0..15.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- daddr  in  32  byte address; bits [log2(DEPTH_WORDS)+1:2] select the word; upper bits ignored (wrap).
- dreq  in  1  access request; held by the initiator until dready_n is seen low.
- dwrite  in  1  1 = store, 0 = load; meaningful only with dreq.
- dsize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- input_ddata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- output_ddata  out  32  load data, right-aligned, zero-extended; 0 whenever dready_n=1.
- dbusy  out  1  access in progress; initiator stalls while high.
- dready_n  out  1  low for exactly one cycle when the access completes.
- dmisalign  out  1  high with dready_n low when the completed access was misaligned.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with dreq=1, latch daddr, dwrite, dsize, input_ddata; load counter with LATENCY; go to WAIT, or directly to RESP if LATENCY=0.
- WAIT: counter decrements each edge; on the edge where it equals 1, go to RESP.
- RESP: dready_n=0. A store commits its byte enables into the array on the edge leaving RESP. A load drives output_ddata from the array read during this cycle. Next state is always IDLE; dreq in RESP is never accepted, because it is the same held request.
- dbusy = (IDLE and dreq) or WAIT. It is combinational on dreq in IDLE, so the initiator stalls in the request cycle itself.
- Lane rules, little-endian:
  - Byte: lane daddr[1:0].
  - Half: lanes {daddr[1],0}+{1,0}.
  - Word: all lanes.
  - Loads are shifted down to bit 0 and zero-extended; sign extension belongs to writeback.
- Misalignment:
  - Applies to a half with daddr[0]=1, or a word with daddr[1:0]!=0.
  - The store is suppressed and load data is 0.
  - dmisalign=1 in the RESP cycle.
- Reset (any time, including in WAIT/RESP):
  - FSM goes to IDLE; the pending access is dropped with no write.
  - dbusy=0, dready_n=1, output_ddata=0, dmisalign=0.
  - Array contents are not reset.

## Timing
- Acceptance edge E0. dready_n=0 in the cycle between E0+L and E0+L+1, where L=LATENCY. FSM is back in IDLE after E0+L+1.
- Throughput: one access per L+2 cycles with dreq held continuously.
- dbusy is high from the request cycle through the last WAIT cycle, and low in RESP.
- Store followed immediately by a load to the same word: the load returns the new data, because the commit at RESP exit precedes the next access.
- input_ddata, daddr and dsize may change after E0 without effect.

## Structure
- Package dmem_pkg:
  - DSIZE_BYTE/HALF/WORD localparams.
  - FSM state enum {IDLE, WAIT, RESP}.
  - LATENCY width constant (4 bits).
- Sub-module dmem_lane_align, combinational:
  - Inputs: addr[1:0], size, wdata, rword.
  - Outputs: byte-enable[3:0], shifted write word, right-aligned zero-extended read data, misalign flag.
- Top level holds the FSM, counter, request latches and the array (inferred RAM, byte-enable write).

## Test plan
- Reset: rst low mid-WAIT of a store to 0x10 -> dbusy=0, dready_n=1, output_ddata=0; a later load of 0x10 returns its prior value.
- Word store then load, LATENCY=2:
  - Store 0xDEADBEEF to 0x40, then load 0x40.
  - Each access: dready_n low exactly at E0+2..E0+3.
  - Load returns 0xDEADBEEF.
- Byte/half lanes:
  - Store byte 0xAA to 0x41, then half 0x1234 to 0x42.
  - Word load of 0x40 returns 0x1234AAEF.
  - Byte load of 0x43 returns 0x00000012.
- Misalignment:
  - Half store to 0x45 -> dmisalign=1 with dready_n low; word at 0x44 unchanged.
  - Word load of 0x46 -> output_ddata=0, dmisalign=1.
- LATENCY=0 back-to-back: dreq held across two requests -> dready_n low every second cycle; dbusy low in RESP cycles; no double acceptance.
- Wrap, DEPTH_WORDS=1024: store 0x11 to 0x1000, load 0x0 -> 0x00000011.
